// File: rtl/bin2seg_if.sv
// Handshake and result bundle between a requester and the bin2seg converter.
// The master issues start/bin; the slave returns status and display data.
interface bin2seg_if;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [31:0] LED;
  logic        ovf;

  modport master (
    output start, bin,
    input  busy, done, bcd, LED, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, LED, ovf
  );
endinterface

// File: rtl/bin2seg_conv.sv
// 16-bit binary to 4-digit BCD converter (serial double dabble)
// with registered seven-segment patterns and saturation at 9999.
module bin2seg_conv #(
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  bin2seg_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_e;

  state_e      state_q;
  logic [15:0] bin_q;
  logic [15:0] sh_q;
  logic [15:0] acc_q;
  logic [3:0]  cnt_q;
  logic [15:0] bcd_q;
  logic [31:0] led_q;
  logic        busy_q;
  logic        done_q;
  logic        ovf_q;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] dab(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  logic [15:0] acc_adj;
  logic [31:0] sh_nxt;
  logic        ovf_d;
  logic [15:0] res_d;
  logic        z3;
  logic        z2;
  logic        z1;
  logic [31:0] led_d;

  always_comb begin
    acc_adj = {dab(acc_q[15:12]), dab(acc_q[11:8]),
               dab(acc_q[7:4]), dab(acc_q[3:0])};
    sh_nxt  = {acc_adj, sh_q} << 1;
  end

  // Out-of-range values saturate to 9999 with ovf flagged.
  always_comb begin
    ovf_d = (bin_q > 16'd9999);
    res_d = ovf_d ? 16'h9999 : acc_q;
    z3    = (res_d[15:12] == 4'd0);
    z2    = z3 && (res_d[11:8] == 4'd0);
    z1    = z2 && (res_d[7:4] == 4'd0);
    led_d = {
      (LZ_BLANK && z3) ? 8'h00 : seg7(res_d[15:12]),
      (LZ_BLANK && z2) ? 8'h00 : seg7(res_d[11:8]),
      (LZ_BLANK && z1) ? 8'h00 : seg7(res_d[7:4]),
      seg7(res_d[3:0])
    };
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      led_q   <= 32'h3F3F3F3F;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            bin_q   <= bus.bin;
            sh_q    <= bus.bin;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= sh_nxt[31:16];
          sh_q  <= sh_nxt[15:0];
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= OUT;
          end
        end
        OUT: begin
          bcd_q   <= res_d;
          led_q   <= led_d;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.LED  = led_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin2seg_conv.sv
// Scoreboard bench for bin2seg_conv: one instance per LZ_BLANK setting,
// driven in lockstep, checked by a monitor against hand-computed vectors.
module tb_bin2seg_conv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin2seg_if b0 ();
  bin2seg_if b1 ();

  bin2seg_conv #(.LZ_BLANK(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  bin2seg_conv #(.LZ_BLANK(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    logic [15:0] bin;
    logic [15:0] bcd;
    logic [31:0] led0;
    logic [31:0] led1;
    logic        ovf;
  } vec_t;

  typedef struct {
    vec_t v;
    int   t;
  } exp_t;

  vec_t vt [13] = '{
    '{16'd1234,  16'h1234, 32'h065B4F66, 32'h065B4F66, 1'b0},
    '{16'd0,     16'h0000, 32'h3F3F3F3F, 32'h0000003F, 1'b0},
    '{16'd7,     16'h0007, 32'h3F3F3F07, 32'h00000007, 1'b0},
    '{16'd305,   16'h0305, 32'h3F4F3F6D, 32'h004F3F6D, 1'b0},
    '{16'd65535, 16'h9999, 32'h6F6F6F6F, 32'h6F6F6F6F, 1'b1},
    '{16'd9999,  16'h9999, 32'h6F6F6F6F, 32'h6F6F6F6F, 1'b0},
    '{16'd10000, 16'h9999, 32'h6F6F6F6F, 32'h6F6F6F6F, 1'b1},
    '{16'd42,    16'h0042, 32'h3F3F665B, 32'h0000665B, 1'b0},
    '{16'd4321,  16'h4321, 32'h664F5B06, 32'h664F5B06, 1'b0},
    '{16'd1,     16'h0001, 32'h3F3F3F06, 32'h00000006, 1'b0},
    '{16'd10,    16'h0010, 32'h3F3F063F, 32'h0000063F, 1'b0},
    '{16'd100,   16'h0100, 32'h3F063F3F, 32'h00063F3F, 1'b0},
    '{16'd1000,  16'h1000, 32'h063F3F3F, 32'h063F3F3F, 1'b0}
  };

  exp_t sb [$];
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int falls = 0;
  int run = 0;
  int last_run = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (b0.busy) run++;
    if (prev_busy && !b0.busy && !rst) begin
      falls++;
      last_run = run;
    end
    if (!b0.busy) run = 0;
    prev_busy = b0.busy;
    if (!rst && b0.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bcd", {16'h0, b0.bcd}, {16'h0, e.v.bcd});
        chk("led_lz0", b0.LED, e.v.led0);
        chk("led_lz1", b1.LED, e.v.led1);
        chk("ovf", {31'h0, b0.ovf}, {31'h0, e.v.ovf});
        chk("done_lz1", {31'h0, b1.done}, 32'd1);
        chk("latency", cyc - e.t, 32'd17);
      end
    end
  end

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [15:0] b);
    b0.start = s;
    b1.start = s;
    b0.bin = b;
    b1.bin = b;
  endtask

  task automatic launch(input int i, input bit push);
    exp_t e;
    e.v = vt[i];
    e.t = cyc + 1;
    if (push) sb.push_back(e);
    drive(1'b1, vt[i].bin);
  endtask

  task automatic wait_done(input int n);
    int k;
    for (k = 0; k < 40; k++) begin
      if (done_cnt >= n) break;
      negs(1);
    end
    if (done_cnt < n) chk("done_timeout", done_cnt, n);
  endtask

  task automatic conv(input int i);
    int n;
    n = done_cnt + 1;
    launch(i, 1'b1);
    negs(1);
    drive(1'b0, 16'($urandom));
    wait_done(n);
    negs(1);
    chk("busy_len", last_run, 32'd17);
    negs(3);
    chk("hold_bcd", {16'h0, b0.bcd}, {16'h0, vt[i].bcd});
  endtask

  initial begin
    int n;
    int f0;
    drive(1'b0, 16'h0);
    negs(2);
    chk("rst_busy", {31'h0, b0.busy}, 32'd0);
    chk("rst_done", {31'h0, b0.done}, 32'd0);
    chk("rst_bcd", {16'h0, b0.bcd}, 32'd0);
    chk("rst_ovf", {31'h0, b0.ovf}, 32'd0);
    chk("rst_led_lz0", b0.LED, 32'h3F3F3F3F);
    chk("rst_led_lz1", b1.LED, 32'h3F3F3F3F);
    rst = 1'b0;
    negs(2);

    for (int i = 0; i < 7; i++) conv(i);

    // Starts during busy cycles 1, 9 and 17 must be dropped.
    n = done_cnt + 1;
    f0 = falls;
    launch(7, 1'b1);
    negs(1);
    drive(1'b1, 16'd8);
    negs(1);
    drive(1'b0, 16'd8);
    negs(7);
    drive(1'b1, 16'd8);
    negs(1);
    drive(1'b0, 16'd8);
    negs(7);
    drive(1'b1, 16'd8);
    negs(1);
    drive(1'b0, 16'd8);
    wait_done(n);
    negs(25);
    chk("ignored_done_cnt", done_cnt, n);
    chk("ignored_busy_falls", falls - f0, 32'd1);

    // Reset five cycles into SHIFT aborts silently.
    n = done_cnt;
    launch(8, 1'b0);
    negs(1);
    drive(1'b0, 16'd0);
    negs(5);
    rst = 1'b1;
    negs(1);
    rst = 1'b0;
    negs(25);
    chk("abort_no_done", done_cnt, n);
    chk("abort_led", b0.LED, 32'h3F3F3F3F);
    chk("abort_busy", {31'h0, b0.busy}, 32'd0);
    chk("abort_bcd", {16'h0, b0.bcd}, 32'd0);
    conv(8);

    // Back-to-back: each new start issued while done is high.
    n = done_cnt;
    launch(9, 1'b1);
    negs(1);
    drive(1'b0, 16'h0);
    for (int i = 10; i < 13; i++) begin
      n++;
      wait_done(n);
      chk("b2b_done_now", {31'h0, b0.done}, 32'd1);
      launch(i, 1'b1);
      negs(1);
      drive(1'b0, 16'h0);
    end
    wait_done(n + 1);
    negs(5);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
